// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package hazard_pkg;

  localparam int unsigned NRegsDef = 16;
  localparam int unsigned WbLatDef = 3;

  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdEx  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StFlush
  } hz_state_t;

  typedef struct packed {
    logic     stall;
    fwd_sel_t fwd;
  } src_res_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register writeback countdown scoreboard with load flags and source lookups.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NRegs = NRegsDef,
  parameter int unsigned WbLat = WbLatDef,
  localparam int unsigned AddrW = $clog2(NRegs),
  localparam int unsigned CntW  = $clog2(WbLat + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_i,
  input  logic             wre_i,
  input  logic             is_load_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [AddrW-1:0] rd_a1_i,
  input  logic [AddrW-1:0] rd_a2_i,
  input  logic [AddrW-1:0] rd_a3_i,
  output logic [CntW-1:0]  cnt_a1_o,
  output logic [CntW-1:0]  cnt_a2_o,
  output logic [CntW-1:0]  cnt_a3_o,
  output logic             ld_a1_o,
  output logic             ld_a2_o,
  output logic             ld_a3_o
);

  logic [CntW-1:0]  cnt_q [NRegs];
  logic [CntW-1:0]  cnt_d [NRegs];
  logic [NRegs-1:0] ld_q, ld_d;

  // A fresh issue to a register overrides its decrement in the same cycle.
  always_comb begin
    ld_d = ld_q;
    for (int unsigned i = 0; i < NRegs; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : '0;
      if (issue_i && wre_i && (wr_addr_i == AddrW'(i))) begin
        cnt_d[i] = CntW'(WbLat);
        ld_d[i]  = is_load_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NRegs; i++) begin
        cnt_q[i] <= '0;
      end
      ld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt_a1_o = cnt_q[rd_a1_i];
  assign cnt_a2_o = cnt_q[rd_a2_i];
  assign cnt_a3_o = cnt_q[rd_a3_i];
  assign ld_a1_o  = ld_q[rd_a1_i];
  assign ld_a2_o  = ld_q[rd_a2_i];
  assign ld_a3_o  = ld_q[rd_a3_i];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard stall / branch flush controller. Define PIPELINE_HAZARD_FORWARD_EN to
// resolve execute/memory-stage dependences by forwarding instead of stalling.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NRegs    = NRegsDef,
  parameter int unsigned WbLat    = WbLatDef,
  parameter int unsigned FlushCyc = 1,
  localparam int unsigned AddrW = $clog2(NRegs),
  localparam int unsigned CntW  = $clog2(WbLat + 1),
  localparam int unsigned FcW   = $clog2(FlushCyc + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dec_valid_i,
  input  logic [AddrW-1:0] dec_a1_i,
  input  logic [AddrW-1:0] dec_a2_i,
  input  logic [AddrW-1:0] dec_a3_i,
  input  logic             dec_use_a1_i,
  input  logic             dec_use_a2_i,
  input  logic             dec_use_a3_i,
  input  logic             dec_wre_i,
  input  logic             dec_is_load_i,
  input  logic             br_taken_i,
  output logic             stall_fetch_o,
  output logic             stall_decode_o,
  output logic             flush_fetch_o,
  output logic             flush_decode_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [15:0]      stall_count_o
);

  hz_state_t       state_q;
  logic [FcW-1:0]  flush_cnt_q;
  logic [15:0]     stall_cnt_q;
  logic [CntW-1:0] cnt_a1, cnt_a2, cnt_a3;
  logic            ld_a1, ld_a2, ld_a3;
  logic            hazard, stall, issue, in_flush;
  fwd_sel_t        fwd_a, fwd_b;

  assign in_flush = (state_q == StFlush);
  assign stall    = dec_valid_i && hazard && !br_taken_i && !in_flush;
  assign issue    = dec_valid_i && !stall && !br_taken_i && !in_flush;

  hazard_scoreboard #(
    .NRegs(NRegs),
    .WbLat(WbLat)
  ) u_sb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .issue_i  (issue),
    .wre_i    (dec_wre_i),
    .is_load_i(dec_is_load_i),
    .wr_addr_i(dec_a3_i),
    .rd_a1_i  (dec_a1_i),
    .rd_a2_i  (dec_a2_i),
    .rd_a3_i  (dec_a3_i),
    .cnt_a1_o (cnt_a1),
    .cnt_a2_o (cnt_a2),
    .cnt_a3_o (cnt_a3),
    .ld_a1_o  (ld_a1),
    .ld_a2_o  (ld_a2),
    .ld_a3_o  (ld_a3)
  );

`ifdef PIPELINE_HAZARD_FORWARD_EN
  // Count WbLat: producer in execute; WbLat-1: producer in memory.
  function automatic src_res_t fwd_resolve(logic used, logic [CntW-1:0] cnt, logic ld);
    src_res_t r;
    r.stall = 1'b0;
    r.fwd   = FwdRf;
    if (used && (cnt != '0)) begin
      if ((cnt == CntW'(WbLat)) && !ld) begin
        r.fwd = FwdEx;
      end else if (cnt == CntW'(WbLat - 1)) begin
        r.fwd = FwdMem;
      end else begin
        r.stall = 1'b1;
      end
    end
    return r;
  endfunction

  src_res_t res_a, res_b;
  logic     a1_blocked;

  // Operand A carries the store data (a3) when it is used; a1 then has no forward path.
  always_comb begin
    res_a      = dec_use_a3_i ? fwd_resolve(1'b1, cnt_a3, ld_a3)
                              : fwd_resolve(dec_use_a1_i, cnt_a1, ld_a1);
    res_b      = fwd_resolve(dec_use_a2_i, cnt_a2, ld_a2);
    a1_blocked = dec_use_a3_i && dec_use_a1_i && (cnt_a1 != '0);
    hazard     = res_a.stall || res_b.stall || a1_blocked;
    fwd_a      = dec_valid_i ? res_a.fwd : FwdRf;
    fwd_b      = dec_valid_i ? res_b.fwd : FwdRf;
  end
`else
  logic unused_ld;
  assign unused_ld = ^{ld_a1, ld_a2, ld_a3};

  // No regfile write-through, so any outstanding count blocks the reader.
  always_comb begin
    hazard = (dec_use_a1_i && (cnt_a1 != '0)) ||
             (dec_use_a2_i && (cnt_a2 != '0)) ||
             (dec_use_a3_i && (cnt_a3 != '0));
    fwd_a  = FwdRf;
    fwd_b  = FwdRf;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      unique case (state_q)
        StRun, StStall: begin
          if (br_taken_i) begin
            state_q     <= StFlush;
            flush_cnt_q <= FcW'(FlushCyc);
          end else begin
            state_q <= stall ? StStall : StRun;
          end
        end
        StFlush: begin
          if (br_taken_i) begin
            flush_cnt_q <= FcW'(FlushCyc);
          end else if (flush_cnt_q <= FcW'(1)) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign stall_fetch_o  = stall;
  assign stall_decode_o = stall;
  assign flush_fetch_o  = br_taken_i || in_flush;
  assign flush_decode_o = br_taken_i || in_flush;
  assign fwd_a_o        = fwd_a;
  assign fwd_b_o        = fwd_b;
  assign stall_count_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle model compare plus directed scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int WB_LAT    = 3;
  localparam int FLUSH_CYC = 1;

`ifdef PIPELINE_HAZARD_FORWARD_EN
  localparam int B2B_ST = 0, B2B_FA = 1, GAP_ST = 0, GAP_FA = 2;
  localparam int LU_ST  = 1, LU_FA  = 2, WR_ST  = 0, WR_FA  = 1, TOT_ST = 1;
`else
  localparam int B2B_ST = 3, B2B_FA = 0, GAP_ST = 2, GAP_FA = 0;
  localparam int LU_ST  = 3, LU_FA  = 0, WR_ST  = 3, WR_FA  = 0, TOT_ST = 11;
`endif

  logic        clk, rst_n;
  logic        dec_valid, dec_use_a1, dec_use_a2, dec_use_a3, dec_wre, dec_is_load, br_taken;
  logic [3:0]  dec_a1, dec_a2, dec_a3;
  logic        stall_fetch, stall_decode, flush_fetch, flush_decode;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .dec_valid_i   (dec_valid),
    .dec_a1_i      (dec_a1),
    .dec_a2_i      (dec_a2),
    .dec_a3_i      (dec_a3),
    .dec_use_a1_i  (dec_use_a1),
    .dec_use_a2_i  (dec_use_a2),
    .dec_use_a3_i  (dec_use_a3),
    .dec_wre_i     (dec_wre),
    .dec_is_load_i (dec_is_load),
    .br_taken_i    (br_taken),
    .stall_fetch_o (stall_fetch),
    .stall_decode_o(stall_decode),
    .flush_fetch_o (flush_fetch),
    .flush_decode_o(flush_decode),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_count_o (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: outstanding cycles until each register's value reaches the regfile.
  int mcnt [16];
  bit mld  [16];
  int mflush;
  int mstalls;
  bit m_stall, m_issue, m_flush, m_hz;
  int m_fa, m_fb;

  // 0 regfile, 1 execute, 2 memory, 3 must stall.
  function automatic int fsel(bit used, int c, bit l);
    if (!used || c == 0) return 0;
    if (c == WB_LAT && !l) return 1;
    if (c == WB_LAT - 1) return 2;
    return 3;
  endfunction

  always_comb begin
    int ra, rb;
    bit in_fl;
    ra    = 0;
    rb    = 0;
    in_fl = (mflush > 0);
`ifdef PIPELINE_HAZARD_FORWARD_EN
    if (dec_use_a3) ra = fsel(1'b1, mcnt[dec_a3], mld[dec_a3]);
    else            ra = fsel(dec_use_a1, mcnt[dec_a1], mld[dec_a1]);
    rb   = fsel(dec_use_a2, mcnt[dec_a2], mld[dec_a2]);
    m_hz = (ra == 3) || (rb == 3) || (dec_use_a3 && dec_use_a1 && mcnt[dec_a1] != 0);
`else
    m_hz = (dec_use_a1 && mcnt[dec_a1] != 0) || (dec_use_a2 && mcnt[dec_a2] != 0) ||
           (dec_use_a3 && mcnt[dec_a3] != 0);
`endif
    m_fa    = (dec_valid && ra != 3) ? ra : 0;
    m_fb    = (dec_valid && rb != 3) ? rb : 0;
    m_stall = dec_valid && m_hz && !br_taken && !in_fl;
    m_issue = dec_valid && !m_stall && !br_taken && !in_fl;
    m_flush = br_taken || in_fl;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mcnt[i] <= 0;
        mld[i]  <= 1'b0;
      end
      mflush  <= 0;
      mstalls <= 0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (mcnt[i] > 0) mcnt[i] <= mcnt[i] - 1;
      end
      if (m_issue && dec_wre) begin
        mcnt[dec_a3] <= WB_LAT;
        mld[dec_a3]  <= dec_is_load;
      end
      if (br_taken) mflush <= FLUSH_CYC;
      else if (mflush > 0) mflush <= mflush - 1;
      if (m_stall && mstalls < 65535) mstalls <= mstalls + 1;
    end
  end

  always @(negedge clk) begin
    chk("stall_fetch", stall_fetch, m_stall);
    chk("stall_decode", stall_decode, m_stall);
    chk("flush_fetch", flush_fetch, m_flush);
    chk("flush_decode", flush_decode, m_flush);
    chk("fwd_a", fwd_a, m_fa);
    chk("fwd_b", fwd_b, m_fb);
    chk("stall_count", stall_count, mstalls);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Holds one instruction in decode until it issues; reports stall cycles and its fwd_a.
  task automatic send(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                      input logic u1, input logic u2, input logic u3, input logic wre,
                      input logic ld, output int stalls, output int fa);
    dec_valid = 1'b1; dec_a1 = a1; dec_a2 = a2; dec_a3 = a3;
    dec_use_a1 = u1; dec_use_a2 = u2; dec_use_a3 = u3; dec_wre = wre; dec_is_load = ld;
    stalls = 0;
    fa     = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (!stall_decode) begin
        fa = int'(fwd_a);
        tick();
        dec_valid = 1'b0;
        return;
      end
      stalls++;
      tick();
    end
    chk("send_timeout", 1, 0);
    dec_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s, f;
    rst_n = 1'b0; br_taken = 1'b0; dec_valid = 1'b0;
    dec_a1 = '0; dec_a2 = '0; dec_a3 = '0;
    dec_use_a1 = 1'b0; dec_use_a2 = 1'b0; dec_use_a3 = 1'b0; dec_wre = 1'b0; dec_is_load = 1'b0;
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("reset_stall_count", stall_count, 0);
    chk("reset_flush", flush_fetch, 0);

    // Mid-run reset with cnt[8]=2 pending.
    send(4'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, f);
    tick();
    chk("cnt8_before_reset", dut.u_sb.cnt_q[8], 2);
    rst_n = 1'b0;
    #1;
    chk("cnt8_after_reset", dut.u_sb.cnt_q[8], 0);
    chk("stall_count_after_reset", stall_count, 0);
    tick();
    rst_n = 1'b1;

    // Back-to-back RAW: mov r8; sub r2, r8, r1.
    send(4'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, f);
    send(4'd8, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, s, f);
    chk("b2b_stalls", s, B2B_ST);
    chk("b2b_fwd_a", f, B2B_FA);
    chk("b2b_stall_count", stall_count, B2B_ST);
    idle(4);

    // One independent instruction between producer and consumer.
    send(4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, f);
    send(4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, f);
    send(4'd9, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s, f);
    chk("gap_stalls", s, GAP_ST);
    chk("gap_fwd_a", f, GAP_FA);
    idle(4);

    // Load-use: load r4; add r6, r4, r0.
    send(4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, s, f);
    send(4'd4, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, s, f);
    chk("loaduse_stalls", s, LU_ST);
    chk("loaduse_fwd_a", f, LU_FA);
    idle(4);

    // Branch taken while a load-use reader is stalled in decode.
    send(4'd0, 4'd0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, s, f);
    dec_valid = 1'b1; dec_a1 = 4'd10; dec_a2 = 4'd0; dec_a3 = 4'd11;
    dec_use_a1 = 1'b1; dec_use_a2 = 1'b0; dec_use_a3 = 1'b0; dec_wre = 1'b1; dec_is_load = 1'b0;
    #1;
    chk("br_pre_stall", stall_decode, 1);
    #1;
    br_taken = 1'b1;
    #1;
    chk("br_cyc0_flush_fetch", flush_fetch, 1);
    chk("br_cyc0_flush_decode", flush_decode, 1);
    chk("br_cyc0_stall_override", stall_decode, 0);
    tick();
    br_taken = 1'b0;
    #1;
    chk("br_cyc1_flush_fetch", flush_fetch, 1);
    chk("br_cyc1_flush_decode", flush_decode, 1);
    tick();
    dec_valid = 1'b0;
    #1;
    chk("br_cyc2_flush_fetch", flush_fetch, 0);
    chk("br_cnt11_untouched", dut.u_sb.cnt_q[11], 0);
    chk("br_cnt10_counting", dut.u_sb.cnt_q[10], 1);
    idle(4);

    // WAW on r15 three times in a row, then a reader.
    for (int k = 0; k < 3; k++) begin
      send(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, f);
      chk("wrap_cnt15_reload", dut.u_sb.cnt_q[15], 3);
    end
    send(4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s, f);
    chk("wrap_reader_stalls", s, WR_ST);
    chk("wrap_reader_fwd_a", f, WR_FA);
    idle(3);
    chk("final_stall_count", stall_count, TOT_ST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
